// File: rtl/ready_pkg.sv
// ready_pkg: shared definitions for the pre-round ready/start synchroniser.
//   - game-controller state codes (4-bit STATE bus)
//   - fsm_e: synchroniser FSM encoding, also exported on DBG_STATE
//   - is_round_clear(): STATE codes that end a round and release the players
//   - is_answer_phase(): STATE codes of the question/answer part of a round
package ready_pkg;

  localparam logic [3:0] READY_ST = 4'd2;
  localparam logic [3:0] QUESTION = 4'd3;
  localparam logic [3:0] INPUT    = 4'd4;
  localparam logic [3:0] DRAW     = 4'd6;
  localparam logic [3:0] WRONG    = 4'd7;
  localparam logic [3:0] GOOD     = 4'd8;
  localparam logic [3:0] OUCH     = 4'd9;
  localparam logic [3:0] WIN      = 4'd10;
  localparam logic [3:0] LOSE     = 4'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    LAUNCH = 2'd2,
    ARMED  = 2'd3
  } fsm_e;

  function automatic logic is_round_clear(input logic [3:0] st);
    return (st == DRAW) || (st == GOOD) || (st == OUCH) ||
           (st == WIN)  || (st == LOSE);
  endfunction

  function automatic logic is_answer_phase(input logic [3:0] st);
    return (st == QUESTION) || (st == INPUT) || (st == WRONG);
  endfunction

endpackage

// File: rtl/player_ready_slot.sv
// player_ready_slot: one player's character-select index and ready latch.
//   CLK, RST_N  : clock, synchronous active-low reset
//   EN          : player inputs are honoured only while high
//   CLR_CHAR    : force the character index to 0
//   CLR_LATCH   : force the ready latch clear (wins over every player input)
//   SEL_STEP    : advance index, wrapping CHAR_CONFIRM -> 0, only while unready
//   READY_BTN   : set latch, accepted only when the index sits at CHAR_CONFIRM
//   CANCEL      : clear latch; beats a same-cycle ready or step
//   CHAR_NUM    : current character index
//   LATCH       : ready latch
module player_ready_slot #(
  parameter int CHAR_W       = 3,
  parameter int CHAR_CONFIRM = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              CLR_CHAR,
  input  logic              CLR_LATCH,
  input  logic              SEL_STEP,
  input  logic              READY_BTN,
  input  logic              CANCEL,
  output logic [CHAR_W-1:0] CHAR_NUM,
  output logic              LATCH
);

  localparam logic [CHAR_W-1:0] CONFIRM = CHAR_W'(CHAR_CONFIRM);

  logic at_confirm;
  logic accept;
  logic step;

  // The ready check looks at the index before any same-cycle step, and an
  // accepted ready swallows that step.
  assign at_confirm = (CHAR_NUM == CONFIRM);
  assign accept     = EN && !CANCEL && READY_BTN && at_confirm;
  assign step       = EN && !CANCEL && !accept && SEL_STEP && !LATCH;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      CHAR_NUM <= '0;
      LATCH    <= 1'b0;
    end else begin
      if (CLR_CHAR) begin
        CHAR_NUM <= '0;
      end else if (step) begin
        CHAR_NUM <= at_confirm ? '0 : CHAR_NUM + CHAR_W'(1);
      end

      if (CLR_LATCH) begin
        LATCH <= 1'b0;
      end else if (EN && CANCEL) begin
        LATCH <= 1'b0;
      end else if (accept) begin
        LATCH <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ready_sync_n.sv
// ready_sync_n: pre-round ready/start synchroniser for N players.
// Players pick a character and press ready; once every player is ready while
// the game controller sits in READY_ST, a random operand 1..NUM_MAX is drawn
// from a free-running roll and broadcast until the round is cleared.
//   CLK, RST_N : clock, synchronous active-low reset
//   STATE      : game-controller state code
//   SEL_STEP   : per-player character-advance pulse
//   READY_BTN  : per-player ready pulse
//   CANCEL     : per-player un-ready pulse
//   CHAR_NUM   : packed character indices, player i at [i*CHAR_W +: CHAR_W]
//   READY_LED  : ready latches, one cycle late
//   RST_LED    : 1 the cycle after a reset edge
//   GO         : one-cycle launch pulse
//   NUM        : drawn operand, held while NUM_VALID
//   NUM_VALID  : high from launch until round clear
//   TIMEOUT    : one-cycle pulse when partial readiness expires
//   DBG_STATE  : current FSM state (fsm_e encoding)
// Handshake: no valid/ready pairs here; GO/TIMEOUT are single-cycle strobes
// and NUM is qualified by NUM_VALID, stable for as long as NUM_VALID is high.
module ready_sync_n
  import ready_pkg::*;
#(
  parameter int N_PLAYERS     = 2,
  parameter int CHAR_W        = 3,
  parameter int CHAR_CONFIRM  = 3,
  parameter int NUM_W         = 4,
  parameter int NUM_MAX       = 10,
  parameter int TICK_DIV      = 5_000_000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [3:0]                  STATE,
  input  logic [N_PLAYERS-1:0]        SEL_STEP,
  input  logic [N_PLAYERS-1:0]        READY_BTN,
  input  logic [N_PLAYERS-1:0]        CANCEL,
  output logic [N_PLAYERS*CHAR_W-1:0] CHAR_NUM,
  output logic [N_PLAYERS-1:0]        READY_LED,
  output logic                        RST_LED,
  output logic                        GO,
  output logic [NUM_W-1:0]            NUM,
  output logic                        NUM_VALID,
  output logic                        TIMEOUT,
  output logic [1:0]                  DBG_STATE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (NUM_MAX > 1) ? $clog2(NUM_MAX) : 1;
  localparam int TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

  fsm_e             state_q, state_d;
  logic [PW-1:0]    presc_q;
  logic [RW-1:0]    roll_q;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N_PLAYERS-1:0] latch;

  logic             tick;
  logic             all_ready, any_ready, in_ready, clear_st;
  logic             fire, slot_en, clr_char, clr_latch;
  logic             go_d, valid_d, timeout_d;
  logic [NUM_W-1:0] num_d;

  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign all_ready = &latch;
  assign any_ready = |latch;
  assign in_ready  = (STATE == READY_ST);
  assign clear_st  = is_round_clear(STATE);
  assign DBG_STATE = state_q;

  // Timeout only while some, but not all, players are ready and GATHER is
  // staying put this cycle.
  assign fire = (TIMEOUT_TICKS != 0) && (state_q == GATHER) && in_ready &&
                !all_ready && any_ready && (timer_q == TW'(TIMEOUT_TICKS));

  // Player inputs are live only on a GATHER cycle that stays in GATHER.
  assign slot_en   = (state_q == GATHER) && in_ready && !all_ready;
  assign clr_char  = (state_q == IDLE) ||
                     ((state_q == GATHER) && !all_ready && !in_ready);
  assign clr_latch = fire ||
                     ((state_q == GATHER) && !all_ready && clear_st) ||
                     ((state_q == ARMED) && clear_st);

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_slot
    player_ready_slot #(
      .CHAR_W       (CHAR_W),
      .CHAR_CONFIRM (CHAR_CONFIRM)
    ) u_slot (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .EN        (slot_en),
      .CLR_CHAR  (clr_char),
      .CLR_LATCH (clr_latch),
      .SEL_STEP  (SEL_STEP[i]),
      .READY_BTN (READY_BTN[i]),
      .CANCEL    (CANCEL[i]),
      .CHAR_NUM  (CHAR_NUM[i*CHAR_W +: CHAR_W]),
      .LATCH     (latch[i])
    );
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_ready) state_d = GATHER;
      GATHER: begin
        if (all_ready)     state_d = LAUNCH;
        else if (!in_ready) state_d = IDLE;
      end
      LAUNCH:  state_d = ARMED;
      ARMED:   if (clear_st) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: GO/NUM are registered on the edge that enters LAUNCH so
  // the last press reaches GO in two cycles.
  always_comb begin
    go_d      = 1'b0;
    num_d     = NUM;
    valid_d   = NUM_VALID;
    timeout_d = fire;
    timer_d   = '0;
    if ((state_q == GATHER) && all_ready) begin
      go_d    = 1'b1;
      num_d   = NUM_W'(roll_q) + NUM_W'(1);
      valid_d = 1'b1;
    end
    if ((state_q == ARMED) && clear_st) begin
      num_d   = '0;
      valid_d = 1'b0;
    end
    if (slot_en && any_ready && !fire) begin
      timer_d = tick ? timer_q + TW'(1) : timer_q;
    end
  end

  // Prescaler, roll (frozen while ARMED), timer and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc_q   <= '0;
      roll_q    <= '0;
      timer_q   <= '0;
      READY_LED <= '0;
      RST_LED   <= 1'b1;
      GO        <= 1'b0;
      NUM       <= '0;
      NUM_VALID <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      presc_q   <= tick ? '0 : presc_q + PW'(1);
      if (tick && (state_q != ARMED)) begin
        roll_q <= (roll_q == RW'(NUM_MAX - 1)) ? '0 : roll_q + RW'(1);
      end
      timer_q   <= timer_d;
      READY_LED <= latch;
      RST_LED   <= 1'b0;
      GO        <= go_d;
      NUM       <= num_d;
      NUM_VALID <= valid_d;
      TIMEOUT   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ready_sync_n.sv
// tb_ready_sync_n: directed scenarios plus randomized traffic for
// ready_sync_n, scored every cycle against a behavioural model.
module tb_ready_sync_n;

  localparam int N    = 2;
  localparam int CW   = 3;
  localparam int CC   = 3;
  localparam int NW   = 4;
  localparam int NM   = 10;
  localparam int TDIV = 4;
  localparam int TT   = 3;
  localparam int W    = N*CW + N + 1 + 1 + NW + 1 + 1 + 2;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      st = 4'd0;
  logic [N-1:0]    sel = '0, rdy = '0, cxl = '0;
  logic [N*CW-1:0] char_num;
  logic [N-1:0]    ready_led;
  logic            rst_led, go, num_valid, timeout;
  logic [NW-1:0]   num;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  ready_sync_n #(
    .N_PLAYERS(N), .CHAR_W(CW), .CHAR_CONFIRM(CC), .NUM_W(NW),
    .NUM_MAX(NM), .TICK_DIV(TDIV), .TIMEOUT_TICKS(TT)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .STATE(st), .SEL_STEP(sel), .READY_BTN(rdy),
    .CANCEL(cxl), .CHAR_NUM(char_num), .READY_LED(ready_led),
    .RST_LED(rst_led), .GO(go), .NUM(num), .NUM_VALID(num_valid),
    .TIMEOUT(timeout), .DBG_STATE(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int go_cnt = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 gathering, 2 launching, 3 armed
  int   m_phase = 0, m_presc = 0, m_roll = 0, m_timer = 0, m_num = 0;
  bit   m_valid = 0, m_go = 0, m_to = 0, m_rstled = 0;
  int   m_char[N];
  bit   m_latch[N];
  logic [N-1:0] m_led = '0;

  function automatic bit round_clear(input int s);
    return (s == 6) || (s == 8) || (s == 9) || (s == 10) || (s == 11);
  endfunction

  task automatic model_step();
    bit all_r, any_r, tick;
    int old_phase;
    if (!rst_n) begin
      m_phase = 0; m_presc = 0; m_roll = 0; m_timer = 0; m_num = 0;
      m_valid = 0; m_go = 0; m_to = 0; m_rstled = 1; m_led = '0;
      for (int i = 0; i < N; i++) begin m_char[i] = 0; m_latch[i] = 0; end
    end else begin
      tick = (m_presc == TDIV - 1);
      old_phase = m_phase;
      all_r = 1; any_r = 0;
      for (int i = 0; i < N; i++) begin
        all_r &= m_latch[i];
        any_r |= m_latch[i];
        m_led[i] = m_latch[i];
      end
      m_rstled = 0; m_go = 0; m_to = 0;
      case (m_phase)
        0: begin
          for (int i = 0; i < N; i++) m_char[i] = 0;
          m_timer = 0;
          if (st == 2) m_phase = 1;
        end
        1: begin
          if (all_r) begin
            m_go = 1; m_num = m_roll + 1; m_valid = 1; m_phase = 2; m_timer = 0;
          end else if (st != 2) begin
            for (int i = 0; i < N; i++) begin
              m_char[i] = 0;
              if (round_clear(st)) m_latch[i] = 0;
            end
            m_phase = 0; m_timer = 0;
          end else if (TT != 0 && any_r && m_timer == TT) begin
            m_to = 1; m_timer = 0;
            for (int i = 0; i < N; i++) m_latch[i] = 0;
          end else begin
            for (int i = 0; i < N; i++) begin
              if (cxl[i]) m_latch[i] = 0;
              else if (rdy[i] && m_char[i] == CC) m_latch[i] = 1;
              else if (sel[i] && !m_latch[i]) m_char[i] = (m_char[i] == CC) ? 0 : m_char[i] + 1;
            end
            m_timer = any_r ? m_timer + (tick ? 1 : 0) : 0;
          end
        end
        2: begin m_phase = 3; m_timer = 0; end
        default: begin
          m_timer = 0;
          if (round_clear(st)) begin
            for (int i = 0; i < N; i++) m_latch[i] = 0;
            m_num = 0; m_valid = 0; m_phase = 0;
          end
        end
      endcase
      if (tick && old_phase != 3) m_roll = (m_roll + 1) % NM;
      m_presc = (m_presc + 1) % TDIV;
    end
  endtask

  function automatic logic [W-1:0] pack_exp();
    logic [N*CW-1:0] c;
    for (int i = 0; i < N; i++) c[i*CW +: CW] = CW'(m_char[i]);
    return {c, m_led, m_rstled, m_go, NW'(m_num), m_valid, m_to, 2'(m_phase)};
  endfunction

  always @(posedge clk) begin
    model_step();
    exp_q.push_back(pack_exp());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {char_num, ready_led, rst_led, go, num, num_valid, timeout, dbg_state};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_cmp cyc=%0d got=%h expected=%h (char %h/%h led %b/%b go %b/%b num %0d/%0d valid %b/%b to %b/%b st %0d/%0d)",
                 cyc, a, e, char_num, e[W-1 -: N*CW], ready_led, e[W-N*CW-1 -: N],
                 go, e[NW+4], num, e[NW+3:4], num_valid, e[3], timeout, e[2], dbg_state, e[1:0]);
      end
      if (go === 1'b1) go_cnt++;
    end
  end

  // ---------------- driver tasks / literal checks ----------------
  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [N-1:0] s, input logic [N-1:0] r, input logic [N-1:0] c);
    sel = s; rdy = r; cxl = c;
    @(negedge clk);
    sel = '0; rdy = '0; cxl = '0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NW-1:0] num0;
    int go_base;
    bit saw;

    // Reset and basic launch
    cyc_n(2);
    check("reset_rst_led", 32'(rst_led), 1);
    check("reset_char", 32'(char_num), 0);
    check("reset_valid", 32'(num_valid), 0);
    rst_n = 1'b1;
    cyc_n(1);
    check("rst_led_drop", 32'(rst_led), 0);
    st = 4'd2;
    cyc_n(1);
    check("enter_gather", 32'(dbg_state), 1);
    repeat (3) pulse(2'b11, 2'b00, 2'b00);
    check("char_after_3_steps", 32'(char_num), 32'h1b);
    pulse(2'b00, 2'b11, 2'b00);
    cyc_n(1);
    check("go_two_cycles", 32'(go), 1);
    check("ready_led_11", 32'(ready_led), 3);
    check("valid_with_go", 32'(num_valid), 1);
    check("num_in_range", 32'((num >= 1) && (num <= NM)), 1);
    num0 = num;
    cyc_n(1);
    check("go_one_cycle", 32'(go), 0);
    check("armed", 32'(dbg_state), 3);
    cyc_n(40);
    check("num_held_armed", 32'(num), 32'(num0));
    st = 4'd8;
    cyc_n(1);
    check("clear_valid", 32'(num_valid), 0);
    check("clear_num", 32'(num), 0);
    check("clear_idle", 32'(dbg_state), 0);
    st = 4'd0;
    cyc_n(8);

    // Select rules
    st = 4'd2;
    cyc_n(1);
    repeat (4) pulse(2'b10, 2'b00, 2'b00);
    check("p1_wrap", 32'(char_num[5:3]), 0);
    repeat (2) pulse(2'b01, 2'b00, 2'b00);
    pulse(2'b00, 2'b01, 2'b00);
    cyc_n(1);
    check("ready_at_2_ignored", 32'(ready_led), 0);
    pulse(2'b01, 2'b00, 2'b00);
    pulse(2'b00, 2'b01, 2'b00);
    pulse(2'b01, 2'b00, 2'b00);
    check("step_ignored_when_ready", 32'(char_num[2:0]), 3);
    cyc_n(1);
    check("p0_led", 32'(ready_led), 1);
    pulse(2'b00, 2'b00, 2'b01);
    cyc_n(1);
    check("p0_cancel_led", 32'(ready_led), 0);

    // Timeout
    repeat (3) pulse(2'b10, 2'b00, 2'b00);
    go_base = go_cnt;
    pulse(2'b00, 2'b01, 2'b00);
    saw = 0;
    for (int k = 0; k < 24 && !saw; k++) begin
      @(negedge clk);
      if (timeout === 1'b1) saw = 1;
    end
    check("timeout_seen", 32'(saw), 1);
    cyc_n(1);
    check("timeout_pulse_1cyc", 32'(timeout), 0);
    check("timeout_led_clear", 32'(ready_led), 0);
    check("timeout_no_go", 32'(go_cnt - go_base), 0);

    // Cancel beats same-cycle last ready
    pulse(2'b00, 2'b01, 2'b00);
    pulse(2'b00, 2'b10, 2'b10);
    cyc_n(1);
    check("cancel_wins_led", 32'(ready_led), 1);
    cyc_n(1);
    check("cancel_no_go", 32'(go_cnt - go_base), 0);
    pulse(2'b00, 2'b00, 2'b01);
    cyc_n(1);
    check("cancel_p0_led", 32'(ready_led), 0);

    // Reset while armed
    pulse(2'b00, 2'b11, 2'b00);
    cyc_n(1);
    check("go_second_launch", 32'(go), 1);
    cyc_n(1);
    rst_n = 1'b0;
    cyc_n(1);
    check("rst_armed_num", 32'(num), 0);
    check("rst_armed_valid", 32'(num_valid), 0);
    check("rst_armed_led", 32'(rst_led), 1);
    check("rst_armed_idle", 32'(dbg_state), 0);
    rst_n = 1'b1;
    cyc_n(1);
    check("rst_led_one_cycle", 32'(rst_led), 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0)
        st = ($urandom_range(0, 1) == 0) ? 4'd2 : 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        sel[i] = ($urandom_range(0, 2) == 0);
        rdy[i] = ($urandom_range(0, 3) == 0);
        cxl[i] = ($urandom_range(0, 11) == 0);
      end
      @(negedge clk);
    end
    sel = '0; rdy = '0; cxl = '0;
    cyc_n(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ready_sync_n.md
Name: ready_sync_n

Overview:
- Generalised pre-round ready/start synchroniser for the multi-player factorization game; successor of the fixed two-player ready block.
- Per player: character-select index and a ready latch.
- When every player is ready while the game controller reports READY, draws a random operand 1..NUM_MAX and broadcasts it with a valid flag.
- Adds cancel, a ready timeout and a one-cycle GO pulse.

Parameters:
N_PLAYERS, 2, number of players (1..8)
CHAR_W, 3, width of each character-select index
CHAR_CONFIRM, 3, top index; select wraps CHAR_CONFIRM->0; ready accepted only at this index
NUM_W, 4, width of drawn number
NUM_MAX, 10, drawn number range 1..NUM_MAX (must fit NUM_W)
TICK_DIV, 5_000_000, CLK cycles per roll/timeout tick
TIMEOUT_TICKS, 30, ticks allowed for partial readiness; 0 disables timeout

Ports:
CLK  in  1  system clock; one clock for the whole block
RST_N  in  1  reset, synchronous, active-low
STATE  in  4  game-controller state code
SEL_STEP  in  N_PLAYERS  per-player one-cycle char-advance pulse
READY_BTN  in  N_PLAYERS  per-player one-cycle ready pulse
CANCEL  in  N_PLAYERS  per-player one-cycle un-ready pulse
CHAR_NUM  out  N_PLAYERS*CHAR_W  packed char indices, player i at [i*CHAR_W +: CHAR_W]
READY_LED  out  N_PLAYERS  registered copy of ready latches
RST_LED  out  1  registered: 1 the cycle after RST_N low
GO  out  1  one-cycle pulse on launch
NUM  out  NUM_W  drawn number, held while NUM_VALID
NUM_VALID  out  1  high from launch until round clear
TIMEOUT  out  1  one-cycle pulse when partial readiness expires

Behaviour:
- All state is registered. When RST_N=0 at a clock edge: FSM->IDLE, CHAR_NUM=0, latches=0, READY_LED=0, GO=0, NUM=0, NUM_VALID=0, TIMEOUT=0, prescaler=0, roll=0, timer=0. RST_LED=1 that cycle, otherwise 0.
- Prescaler: counts 0..TICK_DIV-1; tick is asserted when it reaches TICK_DIV-1, then it wraps to 0.
- Roll: advances 0..NUM_MAX-1 on each tick, wrapping, in every FSM state except ARMED, where it is frozen.
- Round-clear set: STATE in {DRAW=6, GOOD=8, OUCH=9, WIN=10, LOSE=11}. READY_ST=2.
- FSM states and transitions:
  - IDLE: CHAR_NUM forced to 0. Go to GATHER when STATE==READY_ST.
  - GATHER, per player i, priority reset > cancel > ready > step:
    - CANCEL[i]: clear latch i.
    - READY_BTN[i] with CHAR_NUM[i]==CHAR_CONFIRM: set latch i. The check uses the pre-step value; a same-cycle step is ignored.
    - SEL_STEP[i] with latch i clear: index+1, wrapping CHAR_CONFIRM->0.
    - SEL_STEP[i] with latch i set: ignored.
  - GATHER exits:
    - All latches set (evaluated on registered latches) -> LAUNCH.
    - STATE != READY_ST -> IDLE. Latches are kept; CHAR_NUM is cleared.
    - Round-clear STATE -> also clears latches.
  - GATHER timeout:
    - Timer counts ticks while at least one but not all latches are set; it holds at 0 otherwise.
    - When timer reaches TIMEOUT_TICKS (and TIMEOUT_TICKS != 0): TIMEOUT pulses 1 cycle, all latches clear, timer clears, FSM stays in GATHER.
  - LAUNCH (1 cycle): NUM <= roll+1, NUM_VALID <= 1, GO pulses 1 cycle. Next state ARMED.
  - ARMED: NUM/NUM_VALID held; inputs ignored. On round-clear STATE: latches clear, NUM=0, NUM_VALID=0 -> IDLE.
- Latency:
  - Final ready press to GO = 2 cycles (latch set, then LAUNCH registered).
  - NUM_VALID rises the same edge as GO.
- READY_LED mirrors latches with 1-cycle delay.
- Corner cases:
  - Cancel on the same cycle the last player readies: cancel wins for that player, so no launch.
  - N_PLAYERS=1: a single ready launches.
  - Reset mid-ARMED: NUM and NUM_VALID drop at that edge.

Decomposition:
- Shared package ready_pkg: game state codes (READY_ST, QUESTION, INPUT, DRAW, WRONG, GOOD, OUCH, WIN, LOSE), FSM state enum {IDLE, GATHER, LAUNCH, ARMED}, and the is_round_clear(state) function.
- One natural sub-module, player_ready_slot (instantiated N_PLAYERS times): char index, ready latch, cancel/step priority. Prescaler, roll, timer and FSM stay in the top level.

Test Plan (N_PLAYERS=2, TICK_DIV=4, NUM_MAX=10, TIMEOUT_TICKS=3):
- Reset, then STATE=2; step P0 and P1 3 times each; READY_BTN both -> READY_LED=11 the next cycle; GO 1 pulse 2 cycles after the last press; NUM in 1..10 and held; NUM_VALID=1 until STATE=8, then NUM=0, NUM_VALID=0, FSM IDLE.
- READY_BTN[0] at CHAR_NUM[0]=2 -> ignored; step to 3, press -> latch set; SEL_STEP[0] afterwards -> CHAR_NUM[0] stays 3; a 4th step before ready wraps to 0.
- P0 ready only, hold 12 cycles -> TIMEOUT pulse after 3 ticks; READY_LED returns to 00; GO never asserts.
- P0 ready; same cycle P1 ready and CANCEL[1] -> latch1 stays 0, no GO; then CANCEL[0] -> READY_LED=00.
- Launch, then RST_N=0 for 1 cycle while ARMED -> NUM=0, NUM_VALID=0, RST_LED=1 for one cycle, FSM IDLE.
- Roll freeze: after launch, hold ARMED 40 cycles -> NUM unchanged; after round clear, roll resumes advancing every 4 cycles.
